// File: rtl/cp0_intc.sv
// Coprocessor-0 exception controller: edge-detected sources, masking, priority, EPC/Cause/Status.
// Optional EPC/level stack for preemption is enabled by defining CP0_NEST_EN.
module cp0_intc #(
  parameter int unsigned NUM_SRC    = 3,
  parameter int unsigned NEST_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [31:0]        Instruction,
  input  logic [31:0]        PCin,
  input  logic [31:0]        Din,
  input  logic [NUM_SRC-1:0] ExpSrc,
  output logic [31:0]        PCout,
  output logic [31:0]        Dout,
  output logic               ExRegWrite,
  output logic               IsEret,
  output logic               HasExp,
  output logic               ExpBlock
);

  localparam int unsigned CODE_W = 5;
  localparam int unsigned SP_W   = 4;

  if (NUM_SRC < 1 || NUM_SRC > 16 || NEST_DEPTH < 2 || NEST_DEPTH > 8) begin : g_param_check
    $error("cp0_intc: parameter out of range");
  end

  logic [31:0]         epc;
  logic [31:0]         status;
  logic [31:0]         block;
  logic [CODE_W-1:0]   cause_code;
  logic [NUM_SRC-1:0]  pend;
  logic [NUM_SRC-1:0]  prev;

  logic [1:0]          sel;
  logic                mtc0;
  logic                wr_epc;
  logic                wr_status;
  logic                wr_block;
  logic                eret_commit;
  logic [NUM_SRC-1:0]  elig;
  logic [NUM_SRC-1:0]  clr;
  logic [CODE_W-1:0]   code;
  logic                lvl_ok;
  logic                take;
  logic [SP_W-1:0]     sp_rd;
  logic [31:0]         cause_rd;
  logic                unused_bits;

  // Instruction decode
  assign ExRegWrite = ~Instruction[23];
  assign IsEret     = (Instruction[5:0] == 6'b011000);
  assign sel        = Instruction[12:11];
  assign mtc0       = enable & ~ExRegWrite;
  assign wr_epc     = mtc0 && (sel == 2'd0);
  assign wr_status  = mtc0 && (sel == 2'd1);
  assign wr_block   = mtc0 && (sel == 2'd2);

  // Highest eligible index wins; code is index + 1, zero when nothing is eligible
  assign elig = pend & ~block[NUM_SRC-1:0];

  always_comb begin
    code = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (elig[i]) code = CODE_W'(i + 1);
    end
  end

`ifdef CP0_NEST_EN
  localparam int unsigned IDX_W = $clog2(NEST_DEPTH);

  logic [SP_W-1:0]   sp;
  logic [CODE_W-1:0] lvl;
  logic [31:0]       stk_epc [NEST_DEPTH];
  logic [CODE_W-1:0] stk_lvl [NEST_DEPTH];

  assign lvl_ok = (code > lvl) && (sp < SP_W'(NEST_DEPTH));
  assign sp_rd  = sp;
`else
  assign lvl_ok = 1'b1;
  assign sp_rd  = '0;
`endif

  assign take        = (code != '0) & ~status[0] & lvl_ok;
  assign eret_commit = IsEret & enable & ~take;
  assign clr         = take ? (NUM_SRC'(1) << (code - 5'd1)) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      epc        <= '0;
      status     <= '0;
      block      <= '0;
      cause_code <= '0;
      pend       <= '0;
      prev       <= '0;
`ifdef CP0_NEST_EN
      sp  <= '0;
      lvl <= '0;
      for (int i = 0; i < int'(NEST_DEPTH); i++) begin
        stk_epc[i] <= '0;
        stk_lvl[i] <= '0;
      end
`endif
    end else begin
      prev <= ExpSrc;
      // A new rising edge beats the clear of the source being taken
      pend <= (pend & ~clr) | (ExpSrc & ~prev);
      if (wr_block)  block  <= Din;
      if (wr_status) status <= Din;
      if (take) begin
        epc        <= PCin;
        cause_code <= code;
`ifdef CP0_NEST_EN
        stk_epc[IDX_W'(sp)] <= epc;
        stk_lvl[IDX_W'(sp)] <= lvl;
        sp                  <= sp + 1'b1;
        lvl                 <= code;
`else
        status[0] <= 1'b1;
`endif
      end else if (eret_commit) begin
`ifdef CP0_NEST_EN
        if (sp != '0) begin
          epc <= stk_epc[IDX_W'(sp - 1'b1)];
          lvl <= stk_lvl[IDX_W'(sp - 1'b1)];
          sp  <= sp - 1'b1;
        end
`else
        status[0] <= 1'b0;
`endif
      end else if (wr_epc) begin
        epc <= Din;
      end
    end
  end

  // Register read mux; Cause exposes live pending bits above the code field
  assign cause_rd = (32'(pend) << 16) | 32'(cause_code);

  always_comb begin
    Dout = epc;
    case (sel)
      2'd0:    Dout = epc;
      2'd1:    Dout = {status[31:12], sp_rd, status[7:0]};
      2'd2:    Dout = block;
      default: Dout = cause_rd;
    endcase
  end

  assign PCout    = epc;
  assign HasExp   = take;
  assign ExpBlock = status[0];

  assign unused_bits = ^{Instruction[31:24], Instruction[22:13], Instruction[10:6], status[11:8]};

endmodule
